// File: rtl/uram_lookup_sched.sv
// Arbitrates NUM_REQ lookup clients and one host line writer onto the two ports of a
// uram_2rw_reg table, tagging each read so its data returns to the requesting client.
module uram_lookup_sched #(
  parameter int NUM_REQ = 4,
  parameter int AWIDTH  = 16,
  parameter int DWIDTH  = 8,
  parameter int LWIDTH  = 64,
  parameter int RAM_LAT = 2,
  parameter int WR_MAX  = 8
) (
  input  logic                      clock,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*AWIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [NUM_REQ*DWIDTH-1:0] resp_data,
  input  logic                      wr_valid,
  input  logic [AWIDTH-1:0]         wr_addr,
  input  logic [LWIDTH-1:0]         wr_data,
  output logic                      wr_ready,
  output logic                      en_a,
  output logic                      en_b,
  output logic                      wr_en_a,
  output logic                      wr_en_b,
  output logic [AWIDTH-1:0]         address_a,
  output logic [AWIDTH-1:0]         address_b,
  output logic [LWIDTH-1:0]         wr_data_a,
  output logic [LWIDTH-1:0]         wr_data_b,
  input  logic [DWIDTH-1:0]         q_a,
  input  logic [DWIDTH-1:0]         q_b
);

  localparam int IDW      = $clog2(NUM_REQ);
  localparam int SUMW     = IDW + 1;
  localparam int SEL_BITS = $clog2(LWIDTH / DWIDTH);
  localparam int RUNW     = $clog2(WR_MAX + 1);
  localparam int DEPTH    = RAM_LAT + 1;
  localparam logic [SUMW-1:0] NREQ_W  = SUMW'(NUM_REQ);
  localparam logic [RUNW-1:0] RUN_MAX = RUNW'(WR_MAX);

  logic [NUM_REQ-1:0][AWIDTH-1:0] addr_arr;
  logic                           reads_pending;
  logic                           wr_grant;
  logic                           gnt_a;
  logic                           gnt_b;
  logic [IDW-1:0]                 id_a;
  logic [IDW-1:0]                 id_b;
  logic [SUMW-1:0]                scan_sum;
  logic [IDW-1:0]                 scan_idx;
  logic [SUMW-1:0]                last_sum;

  logic [IDW-1:0]                 rr_ptr_q, rr_ptr_d;
  logic [RUNW-1:0]                wr_run_q, wr_run_d;
  logic                           en_a_q, en_a_d;
  logic                           en_b_q, en_b_d;
  logic                           wr_en_a_q, wr_en_a_d;
  logic [AWIDTH-1:0]              address_a_q, address_a_d;
  logic [AWIDTH-1:0]              address_b_q, address_b_d;
  logic [LWIDTH-1:0]              wr_data_a_q, wr_data_a_d;
  logic [DEPTH-1:0]               tag_va_q, tag_va_d;
  logic [DEPTH-1:0]               tag_vb_q, tag_vb_d;
  logic [DEPTH-1:0][IDW-1:0]      tag_ida_q, tag_ida_d;
  logic [DEPTH-1:0][IDW-1:0]      tag_idb_q, tag_idb_d;
  logic [NUM_REQ-1:0]             resp_valid_q, resp_valid_d;
  logic [NUM_REQ-1:0][DWIDTH-1:0] resp_data_q, resp_data_d;

  assign addr_arr      = req_addr;
  assign reads_pending = |req_valid;

  // Round-robin scan: first eligible client takes port B, second takes port A unless
  // the host owns it; reads to the line being written this cycle are skipped.
  always_comb begin
    wr_grant  = rst_n && wr_valid && !(reads_pending && (wr_run_q == RUN_MAX));
    gnt_a     = 1'b0;
    gnt_b     = 1'b0;
    id_a      = '0;
    id_b      = '0;
    req_ready = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_sum = {1'b0, rr_ptr_q} + SUMW'(k);
      if (scan_sum >= NREQ_W) scan_sum = scan_sum - NREQ_W;
      scan_idx = scan_sum[IDW-1:0];
      if (rst_n && req_valid[scan_idx] &&
          !(wr_grant && (addr_arr[scan_idx][AWIDTH-1:SEL_BITS] == wr_addr[AWIDTH-1:SEL_BITS]))) begin
        if (!gnt_b) begin
          gnt_b               = 1'b1;
          id_b                = scan_idx;
          req_ready[scan_idx] = 1'b1;
        end else if (!gnt_a && !wr_grant) begin
          gnt_a               = 1'b1;
          id_a                = scan_idx;
          req_ready[scan_idx] = 1'b1;
        end
      end
    end
    last_sum = {1'b0, (gnt_a ? id_a : id_b)} + SUMW'(1);
    if (last_sum == NREQ_W) last_sum = '0;
    rr_ptr_d = (gnt_a || gnt_b) ? last_sum[IDW-1:0] : rr_ptr_q;
  end

  always_comb begin
    wr_run_d = '0;
    if (wr_grant && reads_pending) wr_run_d = (wr_run_q == RUN_MAX) ? wr_run_q : wr_run_q + RUNW'(1);
    en_b_d      = gnt_b;
    address_b_d = gnt_b ? addr_arr[id_b] : '0;
    en_a_d      = wr_grant || gnt_a;
    wr_en_a_d   = wr_grant;
    address_a_d = wr_grant ? wr_addr : (gnt_a ? addr_arr[id_a] : '0);
    wr_data_a_d = wr_grant ? wr_data : '0;
  end

  // Tag pipes line up with the RAM's registered output so each q lands in its owner's slot.
  always_comb begin
    tag_vb_d     = {tag_vb_q[DEPTH-2:0], gnt_b};
    tag_idb_d    = {tag_idb_q[DEPTH-2:0], id_b};
    tag_va_d     = {tag_va_q[DEPTH-2:0], gnt_a};
    tag_ida_d    = {tag_ida_q[DEPTH-2:0], id_a};
    resp_valid_d = '0;
    resp_data_d  = resp_data_q;
    if (tag_vb_q[DEPTH-1]) begin
      resp_valid_d[tag_idb_q[DEPTH-1]] = 1'b1;
      resp_data_d[tag_idb_q[DEPTH-1]]  = q_b;
    end
    if (tag_va_q[DEPTH-1]) begin
      resp_valid_d[tag_ida_q[DEPTH-1]] = 1'b1;
      resp_data_d[tag_ida_q[DEPTH-1]]  = q_a;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q     <= '0;
      wr_run_q     <= '0;
      en_a_q       <= 1'b0;
      en_b_q       <= 1'b0;
      wr_en_a_q    <= 1'b0;
      address_a_q  <= '0;
      address_b_q  <= '0;
      wr_data_a_q  <= '0;
      tag_va_q     <= '0;
      tag_vb_q     <= '0;
      tag_ida_q    <= '0;
      tag_idb_q    <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      wr_run_q     <= wr_run_d;
      en_a_q       <= en_a_d;
      en_b_q       <= en_b_d;
      wr_en_a_q    <= wr_en_a_d;
      address_a_q  <= address_a_d;
      address_b_q  <= address_b_d;
      wr_data_a_q  <= wr_data_a_d;
      tag_va_q     <= tag_va_d;
      tag_vb_q     <= tag_vb_d;
      tag_ida_q    <= tag_ida_d;
      tag_idb_q    <= tag_idb_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign wr_ready   = wr_grant;
  assign en_a       = en_a_q;
  assign en_b       = en_b_q;
  assign wr_en_a    = wr_en_a_q;
  assign wr_en_b    = 1'b0;
  assign address_a  = address_a_q;
  assign address_b  = address_b_q;
  assign wr_data_a  = wr_data_a_q;
  assign wr_data_b  = '0;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_uram_lookup_sched.sv
// Randomized scoreboard bench for uram_lookup_sched with a behavioural RAM and a
// spec-level arbitration/memory reference model.
module tb_uram_lookup_sched;

  localparam int NUM_REQ = 4;
  localparam int AWIDTH  = 16;
  localparam int DWIDTH  = 8;
  localparam int LWIDTH  = 64;
  localparam int RAM_LAT = 2;
  localparam int WR_MAX  = 8;
  localparam int RESP_DELAY = RAM_LAT + 2;

  logic                      clock = 1'b0;
  logic                      rst_n = 1'b0;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ*AWIDTH-1:0] req_addr = '0;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [NUM_REQ*DWIDTH-1:0] resp_data;
  logic                      wr_valid = 1'b0;
  logic [AWIDTH-1:0]         wr_addr = '0;
  logic [LWIDTH-1:0]         wr_data = '0;
  logic                      wr_ready;
  logic                      en_a, en_b, wr_en_a, wr_en_b;
  logic [AWIDTH-1:0]         address_a, address_b;
  logic [LWIDTH-1:0]         wr_data_a, wr_data_b;
  logic [DWIDTH-1:0]         q_a = '0;
  logic [DWIDTH-1:0]         q_b = '0;

  typedef struct {
    int             id;
    logic [7:0]     data;
    int             due;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] model_mem [int];
  logic [63:0] ram [int];
  int          m_rr = 0;
  int          m_run = 0;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_fail = 0;
  logic [7:0]  rd_a1 = '0;
  logic [7:0]  rd_b1 = '0;

  uram_lookup_sched #(
    .NUM_REQ(NUM_REQ), .AWIDTH(AWIDTH), .DWIDTH(DWIDTH),
    .LWIDTH(LWIDTH), .RAM_LAT(RAM_LAT), .WR_MAX(WR_MAX)
  ) dut (
    .clock(clock), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .en_a(en_a), .en_b(en_b), .wr_en_a(wr_en_a), .wr_en_b(wr_en_b),
    .address_a(address_a), .address_b(address_b),
    .wr_data_a(wr_data_a), .wr_data_b(wr_data_b),
    .q_a(q_a), .q_b(q_b)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Every line starts out holding its own byte addresses, so line 0 = 64'h0706050403020100.
  function automatic logic [63:0] preload_line(int line);
    logic [63:0] v;
    for (int j = 0; j < 8; j++) v[j*8 +: 8] = 8'((line * 8 + j) & 255);
    return v;
  endfunction

  function automatic int line_of(logic [AWIDTH-1:0] a);
    return int'(a[AWIDTH-1:3]);
  endfunction

  function automatic logic [7:0] byte_of(logic [63:0] l, logic [AWIDTH-1:0] a);
    return l[a[2:0]*8 +: 8];
  endfunction

  function automatic logic [63:0] ram_line(int line);
    return ram.exists(line) ? ram[line] : preload_line(line);
  endfunction

  function automatic logic [63:0] model_line(int line);
    return model_mem.exists(line) ? model_mem[line] : preload_line(line);
  endfunction

  // Behavioural two-cycle RAM sitting on the scheduler's port outputs.
  always @(posedge clock) begin
    rd_a1 <= (en_a && !wr_en_a) ? byte_of(ram_line(line_of(address_a)), address_a) : 8'h00;
    rd_b1 <= en_b ? byte_of(ram_line(line_of(address_b)), address_b) : 8'h00;
    q_a   <= rd_a1;
    q_b   <= rd_b1;
    if (en_a && wr_en_a) ram[line_of(address_a)] = wr_data_a;
  end

  task automatic check_output(string name, logic [255:0] act, logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: decides grants from the round-robin/write-priority rules and pushes
  // the byte each granted read must return.
  always @(negedge clock) begin : model_proc
    logic       pending;
    logic       wr_ok;
    int         gb, ga, c, last;
    logic [3:0] exp_ready;
    logic [AWIDTH-1:0] a;
    if (!rst_n) begin
      check_output("reset_ready", {req_ready, wr_ready}, '0);
    end else begin
      pending   = (req_valid != '0);
      wr_ok     = wr_valid && !(pending && m_run == WR_MAX);
      gb        = -1;
      ga        = -1;
      exp_ready = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
        c = (m_rr + k) % NUM_REQ;
        a = req_addr[c*AWIDTH +: AWIDTH];
        if (req_valid[c] && !(wr_ok && line_of(a) == line_of(wr_addr))) begin
          if (gb < 0) gb = c;
          else if (ga < 0 && !wr_ok) ga = c;
        end
      end
      if (gb >= 0) exp_ready[gb] = 1'b1;
      if (ga >= 0) exp_ready[ga] = 1'b1;
      check_output("req_ready", req_ready, exp_ready);
      check_output("wr_ready", wr_ready, wr_ok);
      for (int g = 0; g < 2; g++) begin
        c = (g == 0) ? gb : ga;
        if (c >= 0) begin
          a = req_addr[c*AWIDTH +: AWIDTH];
          sb.push_back('{id: c, data: byte_of(model_line(line_of(a)), a), due: cyc + RESP_DELAY});
        end
      end
      last = (ga >= 0) ? ga : gb;
      if (last >= 0) m_rr = (last + 1) % NUM_REQ;
      m_run = (wr_ok && pending) ? ((m_run + 1 > WR_MAX) ? WR_MAX : m_run + 1) : 0;
      if (wr_ok) model_mem[line_of(wr_addr)] = wr_data;
    end
  end

  // Response monitor: pops due scoreboard entries and compares against resp_valid/resp_data.
  always @(negedge clock) begin : monitor_proc
    logic [3:0] exp_valid;
    if (!rst_n) begin
      check_output("reset_outs",
                   {resp_valid, resp_data, en_a, en_b, wr_en_a, wr_en_b,
                    address_a, address_b, wr_data_a, wr_data_b}, '0);
    end else begin
      exp_valid = '0;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due <= cyc) begin
          exp_valid[sb[i].id] = 1'b1;
          check_output($sformatf("resp_data[%0d]", sb[i].id),
                       resp_data[sb[i].id*DWIDTH +: DWIDTH], sb[i].data);
          sb.delete(i);
        end
      end
      check_output("resp_valid", resp_valid, exp_valid);
    end
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(logic [3:0] v, logic [63:0] addrs, logic wv, logic [15:0] wa, logic [63:0] wd);
    req_valid = v;
    req_addr  = addrs;
    wr_valid  = wv;
    wr_addr   = wa;
    wr_data   = wd;
  endtask

  task automatic apply_stimulus(logic [3:0] v, logic [63:0] addrs, logic wv, logic [15:0] wa, logic [63:0] wd);
    drive(v, addrs, wv, wa, wd);
    next_cycle();
  endtask

  task automatic idle(int n);
    repeat (n) apply_stimulus('0, '0, 1'b0, '0, '0);
  endtask

  task automatic apply_reset(int n);
    rst_n = 1'b0;
    sb.delete();
    m_rr  = 0;
    m_run = 0;
    repeat (n) next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic print_summary();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
  endtask

  initial begin : stim
    logic [31:0] stall_mask;
    logic [63:0] addrs;
    next_cycle();
    apply_reset(3);

    $display("[TB] single read of addr 3");
    apply_stimulus(4'b0001, 64'd3, 1'b0, '0, '0);
    idle(6);

    $display("[TB] all clients streaming addrs 0..3");
    repeat (8) apply_stimulus(4'hF, {16'd3, 16'd2, 16'd1, 16'd0}, 1'b0, '0, '0);
    idle(6);

    $display("[TB] host write burst vs client 1 stream");
    stall_mask = '0;
    for (int k = 1; k <= 20; k++) begin
      drive(4'b0010, {16'd0, 16'd0, 16'(800 + $urandom_range(0, 7)), 16'd0},
            1'b1, 16'(((k - 1) % 12) * 8), {$urandom, $urandom});
      @(negedge clock);
      if (!wr_ready) stall_mask[k] = 1'b1;
      next_cycle();
    end
    check_output("burst_wr_stalls", stall_mask, 32'h0004_0200);
    idle(6);

    $display("[TB] write/read collision on line 5");
    drive(4'b0100, {16'd0, 16'd40, 16'd0, 16'd0}, 1'b1, 16'd40, 64'hAAAA_AAAA_AAAA_AAAA);
    @(negedge clock);
    check_output("coh_block", req_ready[2], 1'b0);
    next_cycle();
    apply_stimulus(4'b0100, {16'd0, 16'd40, 16'd0, 16'd0}, 1'b0, '0, '0);
    idle(6);

    $display("[TB] reset with reads in flight");
    apply_stimulus(4'b0011, {16'd0, 16'd0, 16'd11, 16'd10}, 1'b0, '0, '0);
    drive(4'hF, {16'd3, 16'd2, 16'd1, 16'd0}, 1'b1, 16'd200, 64'h1234);
    apply_reset(3);
    drive(4'hF, {16'd3, 16'd2, 16'd1, 16'd0}, 1'b0, '0, '0);
    @(negedge clock);
    check_output("first_grant_after_reset", req_ready, 4'b0011);
    next_cycle();
    apply_stimulus(4'hF, {16'd3, 16'd2, 16'd1, 16'd0}, 1'b0, '0, '0);
    idle(6);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NUM_REQ; i++) addrs[i*16 +: 16] = 16'($urandom_range(0, 127));
      apply_stimulus(4'($urandom_range(0, 15)), addrs, ($urandom_range(0, 3) != 0),
                     16'($urandom_range(0, 127)), {$urandom, $urandom});
    end
    idle(8);
    check_output("scoreboard_drained", 256'(sb.size()), '0);

    print_summary();
    $finish;
  end

  initial begin : watchdog
    #1000000;
    n_fail++;
    $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    print_summary();
    $finish;
  end

endmodule
